kpn_scheduler: RTL and testbench

Central sequencer for the two-source / one-adder / LCD Kahn process network. It paces the two token queues, fires the adder only when both input FIFOs hold a token and the output FIFO has room, and meters reads from the output FIFO into the BCD/LCD path so each result is held on the display. All strobes are single-cycle registered pulses in the divided KPN clock domain. The block replaces free-running handshakes with one arbitration point.

---
 rtl/kpn_scheduler.sv | 133 +++++++++++++
 tb/tb_kpn_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/kpn_scheduler.sv
// Central sequencer for the two-source / adder / LCD Kahn process network.
// Optional stall statistics: define KPN_SCHED_STATS_EN to enable o_stall_count.
module kpn_scheduler #(
    parameter int TOKEN_COUNT = 16,
    parameter int ADDER_LAT   = 2,
    parameter int LCD_HOLD    = 1000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_fifo_1_full,
    input  logic        i_fifo_2_full,
    input  logic        i_fifo_1_empty,
    input  logic        i_fifo_2_empty,
    input  logic        i_fifo_3_full,
    input  logic        i_fifo_3_empty,
    input  logic        i_lcd_busy,
    output logic        o_queue_1_wr,
    output logic        o_queue_2_wr,
    output logic        o_adder_rd,
    output logic        o_adder_wr,
    output logic        o_lcd_rd,
    output logic        o_done,
    output logic [15:0] o_stall_count
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT, S_WRITE} state_t;

    localparam logic [15:0] TC        = 16'(TOKEN_COUNT);
    localparam logic [3:0]  LAT_INIT  = 4'(ADDER_LAT - 1);
    localparam logic [15:0] HOLD_INIT = 16'(LCD_HOLD - 1);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_lat;
    logic [15:0] r_prod_1, r_prod_2, r_fired, r_disp, r_hold;
    logic        r_q1_wr, r_q2_wr, r_adder_rd, r_adder_wr, r_lcd_rd, r_done;
    logic        w_fire_ok, w_q1_nxt, w_q2_nxt, w_rd_nxt, w_wr_nxt, w_lcd_nxt, w_done_nxt;

    assign w_fire_ok = !i_fifo_1_empty && !i_fifo_2_empty && !i_fifo_3_full;

    // Adder FSM: state register (latency counter rides along with it)
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_lat   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_READ)
                r_lat <= LAT_INIT;
            else if (r_state == S_WAIT)
                r_lat <= r_lat - 4'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_fire_ok) w_state_nxt = S_READ;
            S_READ:  w_state_nxt = (ADDER_LAT == 1) ? S_WRITE : S_WAIT;
            S_WAIT:  if (r_lat <= 4'd1) w_state_nxt = S_WRITE;
            S_WRITE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they leave the block registered
    always_comb begin
        w_rd_nxt = (w_state_nxt == S_READ);
        w_wr_nxt = (w_state_nxt == S_WRITE);
    end

    assign w_q1_nxt   = !i_fifo_1_full && (r_prod_1 < TC);
    assign w_q2_nxt   = !i_fifo_2_full && (r_prod_2 < TC);
    assign w_lcd_nxt  = (r_hold == 16'd0) && !i_fifo_3_empty && !i_lcd_busy;
    assign w_done_nxt = r_done || ((r_prod_1 == TC) && (r_prod_2 == TC) &&
                                   (r_fired == TC) && (r_disp == TC));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_q1_wr    <= 1'b0;
            r_q2_wr    <= 1'b0;
            r_adder_rd <= 1'b0;
            r_adder_wr <= 1'b0;
            r_lcd_rd   <= 1'b0;
            r_done     <= 1'b0;
            r_prod_1   <= 16'd0;
            r_prod_2   <= 16'd0;
            r_fired    <= 16'd0;
            r_disp     <= 16'd0;
            r_hold     <= 16'd0;
        end else begin
            r_q1_wr    <= w_q1_nxt;
            r_q2_wr    <= w_q2_nxt;
            r_adder_rd <= w_rd_nxt;
            r_adder_wr <= w_wr_nxt;
            r_lcd_rd   <= w_lcd_nxt;
            r_done     <= w_done_nxt;
            if (w_q1_nxt) r_prod_1 <= r_prod_1 + 16'd1;
            if (w_q2_nxt) r_prod_2 <= r_prod_2 + 16'd1;
            if (w_wr_nxt) r_fired  <= r_fired + 16'd1;
            if (w_lcd_nxt) begin
                r_hold <= HOLD_INIT;
                r_disp <= r_disp + 16'd1;
            end else if (r_hold != 16'd0) begin
                r_hold <= r_hold - 16'd1;
            end
        end
    end

    assign o_queue_1_wr = r_q1_wr;
    assign o_queue_2_wr = r_q2_wr;
    assign o_adder_rd   = r_adder_rd;
    assign o_adder_wr   = r_adder_wr;
    assign o_lcd_rd     = r_lcd_rd;
    assign o_done       = r_done;

`ifdef KPN_SCHED_STATS_EN
    logic [15:0] r_stall;

    // Counts cycles the adder had both operands but no room downstream
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_stall <= 16'd0;
        else if ((r_state == S_IDLE) && !i_fifo_1_empty && !i_fifo_2_empty &&
                 i_fifo_3_full && (r_stall != 16'hFFFF))
            r_stall <= r_stall + 16'd1;
    end

    assign o_stall_count = r_stall;
`else
    assign o_stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_kpn_scheduler.sv
// Directed bench for kpn_scheduler: vector table plus hand-written multi-cycle sequences.
module tb_kpn_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, f1full, f2full, f1e, f2e, f3full, f3e, busy;
    logic q1, q2, ard, awr, lcd, done;
    logic [15:0] stall;
    logic l_q1, l_q2, l_rd, l_wr, l_lcd, l_done;
    logic [15:0] l_stall;
    logic z_q1, z_q2, z_rd, z_wr, z_lcd, z_done;
    logic [15:0] z_stall;
    logic z_lo = 1'b0;
    logic z_hi = 1'b1;

    int n_chk = 0;
    int n_fail = 0;

    kpn_scheduler #(.TOKEN_COUNT(4), .ADDER_LAT(2), .LCD_HOLD(3)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_fifo_1_full(f1full), .i_fifo_2_full(f2full),
        .i_fifo_1_empty(f1e), .i_fifo_2_empty(f2e),
        .i_fifo_3_full(f3full), .i_fifo_3_empty(f3e), .i_lcd_busy(busy),
        .o_queue_1_wr(q1), .o_queue_2_wr(q2), .o_adder_rd(ard), .o_adder_wr(awr),
        .o_lcd_rd(lcd), .o_done(done), .o_stall_count(stall));

    kpn_scheduler #(.TOKEN_COUNT(16), .ADDER_LAT(2), .LCD_HOLD(5)) u_lcd (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_fifo_1_full(f1full), .i_fifo_2_full(f2full),
        .i_fifo_1_empty(f1e), .i_fifo_2_empty(f2e),
        .i_fifo_3_full(f3full), .i_fifo_3_empty(f3e), .i_lcd_busy(busy),
        .o_queue_1_wr(l_q1), .o_queue_2_wr(l_q2), .o_adder_rd(l_rd), .o_adder_wr(l_wr),
        .o_lcd_rd(l_lcd), .o_done(l_done), .o_stall_count(l_stall));

    kpn_scheduler #(.TOKEN_COUNT(0), .ADDER_LAT(2), .LCD_HOLD(3)) u_zero (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_fifo_1_full(z_lo), .i_fifo_2_full(z_lo),
        .i_fifo_1_empty(z_hi), .i_fifo_2_empty(z_hi),
        .i_fifo_3_full(z_lo), .i_fifo_3_empty(z_hi), .i_lcd_busy(z_lo),
        .o_queue_1_wr(z_q1), .o_queue_2_wr(z_q2), .o_adder_rd(z_rd), .o_adder_wr(z_wr),
        .o_lcd_rd(z_lcd), .o_done(z_done), .o_stall_count(z_stall));

    // in = {rst_n,f1full,f2full,f1e,f2e,f3full,f3e,busy}; exp = {q1,q2,rd,wr,lcd,done}
    typedef struct packed {
        logic [7:0] in;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_flags();
        f1full = 1'b1; f2full = 1'b1; f1e = 1'b1; f2e = 1'b1;
        f3full = 1'b0; f3e = 1'b1; busy = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        chk("rst_outs", {10'd0, q1, q2, ard, awr, lcd, done}, 16'd0);
        rst_n = 1'b1;
    endtask

    int c1, c2, c3, n_q1, n_q2, n_rd, n_wr, n_lcd, last_lcd;
    logic seen_done, done_ok, spacing_err, ovf, prev_lcd, bad;

    initial begin
        vecs[0]  = {8'b0_0_0_1_1_0_1_0, 6'b000000};
        vecs[1]  = {8'b1_1_0_1_1_0_1_0, 6'b010000};
        vecs[2]  = {8'b1_0_1_1_1_0_1_0, 6'b100000};
        vecs[3]  = {8'b1_0_0_0_0_0_1_0, 6'b111000};
        vecs[4]  = {8'b1_0_0_0_0_0_1_0, 6'b110000};
        vecs[5]  = {8'b1_1_1_0_0_0_1_0, 6'b000100};
        vecs[6]  = {8'b1_1_1_0_0_0_0_0, 6'b000010};
        vecs[7]  = {8'b1_1_1_0_0_0_0_0, 6'b001000};
        vecs[8]  = {8'b1_1_1_1_1_0_0_0, 6'b000000};
        vecs[9]  = {8'b1_1_1_1_1_0_0_1, 6'b000100};
        vecs[10] = {8'b1_1_1_1_1_0_0_0, 6'b000010};

        rst_n = 1'b0;
        quiet_flags();
        tick();
        for (int i = 0; i < 11; i++) begin
            {rst_n, f1full, f2full, f1e, f2e, f3full, f3e, busy} = vecs[i].in;
            tick();
            chk($sformatf("vec%0d", i), {10'd0, q1, q2, ard, awr, lcd, done},
                {10'd0, vecs[i].exp});
        end

        // Full flow with 4-deep FIFO flags reflecting strobes before the next edge
        quiet_flags();
        f1full = 1'b0; f2full = 1'b0;
        pulse_reset();
        c1 = 0; c2 = 0; c3 = 0;
        n_q1 = 0; n_q2 = 0; n_rd = 0; n_wr = 0; n_lcd = 0; last_lcd = -10;
        seen_done = 0; done_ok = 0; spacing_err = 0; ovf = 0; prev_lcd = 0;
        for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
            tick();
            n_q1 += int'(q1); n_q2 += int'(q2); n_rd += int'(ard);
            n_wr += int'(awr); n_lcd += int'(lcd);
            if (lcd) begin
                if (cyc - last_lcd < 3) spacing_err = 1;
                last_lcd = cyc;
            end
            if (done) begin
                seen_done = 1;
                done_ok = prev_lcd && (n_lcd == 4);
            end
            prev_lcd = lcd;
            c1 += int'(q1) - int'(ard);
            c2 += int'(q2) - int'(ard);
            c3 += int'(awr) - int'(lcd);
            if (c1 < 0 || c1 > 4 || c2 < 0 || c2 > 4 || c3 < 0 || c3 > 4) ovf = 1;
            f1full = (c1 == 4); f2full = (c2 == 4); f3full = (c3 == 4);
            f1e = (c1 == 0); f2e = (c2 == 0); f3e = (c3 == 0);
        end
        chk("flow_q1", 16'(n_q1), 16'd4);
        chk("flow_q2", 16'(n_q2), 16'd4);
        chk("flow_rd", 16'(n_rd), 16'd4);
        chk("flow_wr", 16'(n_wr), 16'd4);
        chk("flow_lcd", 16'(n_lcd), 16'd4);
        chk("flow_done_seen", {15'd0, seen_done}, 16'd1);
        chk("flow_done_after_lcd", {15'd0, done_ok}, 16'd1);
        chk("flow_lcd_spacing_err", {15'd0, spacing_err}, 16'd0);
        chk("flow_fifo_ovf", {15'd0, ovf}, 16'd0);

        // Reset while the adder is waiting drops the pending write
        quiet_flags();
        pulse_reset();
        f1e = 1'b0; f2e = 1'b0;
        tick();
        chk("mid_rd", {15'd0, ard}, 16'd1);
        f1e = 1'b1; f2e = 1'b1;
        tick();
        chk("mid_wait", {14'd0, ard, awr}, 16'd0);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_outs", {10'd0, q1, q2, ard, awr, lcd, done}, 16'd0);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (awr || ard) bad = 1;
        end
        chk("mid_no_wr", {15'd0, bad}, 16'd0);

        // Fire latency from a fresh IDLE
        f1e = 1'b0; f2e = 1'b0;
        tick();
        chk("lat_rd", {14'd0, ard, awr}, 16'd2);
        f1e = 1'b1; f2e = 1'b1;
        tick();
        chk("lat_wait", {14'd0, ard, awr}, 16'd0);
        tick();
        chk("lat_wr", {14'd0, ard, awr}, 16'd1);

        // Backpressure from the output FIFO
        quiet_flags();
        pulse_reset();
        f1e = 1'b0; f2e = 1'b0; f3full = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ard) bad = 1;
        end
        chk("bp_no_rd", {15'd0, bad}, 16'd0);
`ifdef KPN_SCHED_STATS_EN
        chk("bp_stall", stall, 16'd10);
`else
        chk("bp_stall", stall, 16'd0);
`endif
        f3full = 1'b0;
        tick();
        chk("bp_release_rd", {15'd0, ard}, 16'd1);

        // LCD pacing with LCD_HOLD=5, then busy suppression
        quiet_flags();
        pulse_reset();
        f3e = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk($sformatf("pace%0d", i), {15'd0, l_lcd}, {15'd0, (i % 5) == 0});
        end
        busy = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (l_lcd) bad = 1;
        end
        chk("busy_suppress", {15'd0, bad}, 16'd0);
        busy = 1'b0;
        tick();
        chk("busy_release", {15'd0, l_lcd}, 16'd1);

        // TOKEN_COUNT=0 instance
        quiet_flags();
        rst_n = 1'b0;
        tick();
        chk("zero_done_in_rst", {15'd0, z_done}, 16'd0);
        rst_n = 1'b1;
        tick();
        chk("zero_done_first", {15'd0, z_done}, 16'd1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (z_q1 || z_q2 || z_rd || z_wr || z_lcd || !z_done) bad = 1;
        end
        chk("zero_quiet", {15'd0, bad}, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
